// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial CLA sequencer and its 4-bit stage.
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/cla_nibble_sequencer_if.sv
// Request/result handshake bundle between the sequencer and its client.
interface cla_nibble_sequencer_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

endinterface

// File: rtl/cla4_registered.sv
// 4-bit carry-lookahead adder with registered sum and carry-out (1-cycle latency).
module cla4_registered
  import cla_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                Cin,
  output logic [NIBBLE_W-1:0] Sum_out,
  output logic                Cout_out
);

  logic [NIBBLE_W-1:0] w_g;
  logic [NIBBLE_W-1:0] w_p;
  logic [NIBBLE_W:0]   w_c;

  assign w_g = A & B;
  assign w_p = A ^ B;

  // Every carry is a flat function of g/p/Cin, so no carry ripples through another.
  assign w_c[0] = Cin;
  assign w_c[1] = w_g[0] | (w_p[0] & Cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & Cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Sum_out  <= '0;
      Cout_out <= 1'b0;
    end else begin
      Sum_out  <= w_p ^ w_c[NIBBLE_W-1:0];
      Cout_out <= w_c[NIBBLE_W];
    end
  end

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Slices a WIDTH-bit add into LSB-first nibbles for an external registered 4-bit CLA
// and reassembles the result, chaining the stage's carry-out back in as carry-in.
module cla_nibble_sequencer
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  cla_nibble_sequencer_if.slave bus,
  output logic [NIBBLE_W-1:0]   cla_a,
  output logic [NIBBLE_W-1:0]   cla_b,
  output logic                  cla_cin,
  input  logic [NIBBLE_W-1:0]   cla_sum,
  input  logic                  cla_cout,
  output logic                  busy
);

  localparam int NIBBLES = nib_count(WIDTH);
  localparam int IDX_W   = $clog2(NIBBLES);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 2 * NIBBLE_W) begin : g_bad_width
    $error("cla_nibble_sequencer: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t              r_state, w_state_next;
  logic [IDX_W-1:0]    r_idx, w_idx_next;
  logic [WIDTH-1:0]    r_a, r_b;
  logic                r_cin, r_cout;
  logic [WIDTH-1:0]    w_sum;
  logic [NIBBLE_W-1:0] w_a_nib [NIBBLES];
  logic [NIBBLE_W-1:0] w_b_nib [NIBBLES];
  logic                w_accept;
  logic                w_last;

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    cla_a        = '0;
    cla_b        = '0;
    cla_cin      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = RUN;
          w_idx_next   = '0;
        end
      end
      RUN: begin
        cla_a   = w_a_nib[r_idx];
        cla_b   = w_b_nib[r_idx];
        // The stage's registered carry belongs to the nibble issued last cycle.
        cla_cin = (r_idx == '0) ? r_cin : cla_cout;
        if (w_last) w_state_next = DRAIN;
        else        w_idx_next   = r_idx + 1'b1;
      end
      DRAIN:   w_state_next = DONE;
      DONE:    if (bus.out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_cin  <= 1'b0;
      r_cout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= bus.in_a;
        r_b   <= bus.in_b;
        r_cin <= bus.in_cin;
      end
      if (r_state == DRAIN) r_cout <= cla_cout;
    end
  end

  // Sum nibble gi arrives one cycle after it was issued: during RUN idx gi+1, or DRAIN for the top one.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    logic                r_nib;
    logic [NIBBLE_W-1:0] r_sum_nib;
    logic                w_wr;

    assign w_a_nib[gi] = r_a[NIBBLE_W*gi +: NIBBLE_W];
    assign w_b_nib[gi] = r_b[NIBBLE_W*gi +: NIBBLE_W];

    if (gi == NIBBLES - 1) begin : g_top
      assign w_wr = (r_state == DRAIN);
    end else begin : g_low
      assign w_wr = (r_state == RUN) && (r_idx == IDX_W'(gi + 1));
    end

    always_ff @(posedge Clk) begin
      if (Reset) begin
        r_sum_nib <= '0;
      end else if (w_wr) begin
        r_sum_nib <= cla_sum;
      end
    end

    assign w_sum[NIBBLE_W*gi +: NIBBLE_W] = r_sum_nib;
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_sum   = w_sum;
  assign bus.out_cout  = r_cout;
  assign busy          = (r_state == RUN) || (r_state == DRAIN);

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed and random checks of the sequencer driving a real 4-bit registered CLA stage.
module tb_cla_nibble_sequencer;
  import cla_pkg::*;

  localparam int WIDTH = 16;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] cla_a, cla_b, cla_sum;
  logic       cla_cin, cla_cout, busy;
  int         n_checks = 0;
  int         n_pass = 0;
  int         overlap_cnt = 0;

  cla_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

  cla_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .bus     (bus),
    .cla_a   (cla_a),
    .cla_b   (cla_b),
    .cla_cin (cla_cin),
    .cla_sum (cla_sum),
    .cla_cout(cla_cout),
    .busy    (busy)
  );

  cla4_registered u_cla (
    .Clk     (Clk),
    .Reset   (Reset),
    .A       (cla_a),
    .B       (cla_b),
    .Cin     (cla_cin),
    .Sum_out (cla_sum),
    .Cout_out(cla_cout)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (bus.in_ready === 1'b1 && bus.out_valid === 1'b1) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One full directed transaction; bp = extra DONE cycles with out_ready held low.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input int bp, input string tag);
    logic [16:0] exp;
    logic [16:0] held;
    int          lat;
    exp = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    @(negedge Clk);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_cin    = cin;
    bus.out_ready = 1'b0;
    @(negedge Clk);
    bus.in_valid = 1'b0;
    lat = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_cla_a0"}, 32'(cla_a), 32'(a[3:0]));
    check({tag, "_cla_cin0"}, 32'(cla_cin), 32'(cin));
    while (!bus.out_valid && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd6);
    check({tag, "_result"}, 32'({bus.out_cout, bus.out_sum}), 32'(exp));
    held = {bus.out_cout, bus.out_sum};
    repeat (bp) begin
      @(negedge Clk);
      check({tag, "_hold"}, 32'({bus.out_valid, bus.out_cout, bus.out_sum}), 32'({1'b1, held}));
      check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge Clk);
    bus.out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_post_keep"}, 32'({bus.out_cout, bus.out_sum}), 32'(exp));
    $display("op %s: %h + %h + %0d -> %h cout=%0d", tag, a, b, cin, bus.out_sum, bus.out_cout);
  endtask

  task automatic rand_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input int gap, input int bp, input int k);
    logic [16:0] exp;
    int          lat;
    exp = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    repeat (gap) @(negedge Clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    @(negedge Clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    if (!bus.out_valid) begin
      check("rand_timeout", 32'd0, 32'd1);
    end else begin
      repeat (bp) @(negedge Clk);
      check("rand_result", 32'({bus.out_cout, bus.out_sum}), 32'(exp));
      $display("rand %0d: %h + %h + %0d -> %h cout=%0d", k, a, b, cin, bus.out_sum, bus.out_cout);
      bus.out_ready = 1'b1;
      @(negedge Clk);
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    int lat;
    Reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", 32'({bus.out_cout, bus.out_sum}), 32'd0);
    check("rst_cla", 32'({cla_a, cla_b, cla_cin}), 32'd0);
    Reset = 1'b0;

    do_op(16'hFFFF, 16'h0001, 1'b0, 0, "ffff_p1");
    do_op(16'h1234, 16'h4321, 1'b1, 3, "bp3");
    do_op(16'h0FFF, 16'h0001, 1'b0, 0, "ripple3");

    // Back-to-back with in_valid held high and out_ready high.
    @(negedge Clk);
    bus.in_valid  = 1'b1;
    bus.in_a      = 16'hABCD;
    bus.in_b      = 16'h1111;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge Clk);
    bus.in_a   = 16'hFFFF;
    bus.in_b   = 16'hFFFF;
    bus.in_cin = 1'b1;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    check("b2b1_latency", 32'(lat), 32'd6);
    check("b2b1_result", 32'({bus.out_cout, bus.out_sum}), 32'h0BCDE);
    @(negedge Clk);
    check("b2b2_accept_ready", 32'(bus.in_ready), 32'd1);
    @(negedge Clk);
    check("b2b2_accept_busy", 32'(busy), 32'd1);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    check("b2b2_latency", 32'(lat), 32'd6);
    check("b2b2_result", 32'({bus.out_cout, bus.out_sum}), 32'h1FFFF);
    $display("op b2b: abcd + 1111 + 0 then ffff + ffff + 1 -> %h cout=%0d", bus.out_sum, bus.out_cout);
    @(negedge Clk);
    bus.out_ready = 1'b0;

    // Abort while the third nibble is being issued.
    @(negedge Clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h1111;
    bus.in_b     = 16'h2222;
    bus.in_cin   = 1'b0;
    @(negedge Clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge Clk);
    check("mid_cla_a2", 32'(cla_a), 32'h1);
    Reset = 1'b1;
    @(negedge Clk);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cla", 32'({cla_a, cla_b, cla_cin}), 32'd0);
    check("mid_rst_out", 32'({bus.out_cout, bus.out_sum}), 32'd0);
    $display("op reset: aborted 1111 + 2222 during nibble 2");
    Reset = 1'b0;
    do_op(16'h8000, 16'h8000, 1'b0, 1, "after_rst");

    for (int k = 0; k < 1000; k++) begin
      rand_op(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), k);
    end

    check("no_overlap", 32'(overlap_cnt), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
